// File: rtl/frame_stream_gen.sv
// frame_stream_gen
// Pixel-stream source for the image-processing pipeline. Generates complete
// frames as a vsync/href/clken/24-bit RGB stream with programmable geometry
// and selectable test patterns. Every output is flop-driven.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   en           run request, sampled only at frame boundaries
//   mode         0 colour bars, 1 gradient, 2 {y,x} counter, 3 solid
//   solid_rgb    colour for mode 3
//   stall        downstream backpressure; freezes generation while high
//   frame_vsync  high during the VSYNC lines (including their blanking)
//   frame_href   high during active pixels of active lines
//   frame_clken  pixel valid (href gated by the previously sampled stall)
//   frame_data   {R,G,B}; 0 when frame_clken is low
//   frame_done   one-cycle pulse after the last active pixel of a frame
//   busy         high in every state except IDLE
module frame_stream_gen #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_BLANK     = 160,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned VSYNC_LINES = 2,
   parameter int unsigned V_BACK      = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [23:0] solid_rgb,
   input  logic        stall,
   output logic        frame_vsync,
   output logic        frame_href,
   output logic        frame_clken,
   output logic [23:0] frame_data,
   output logic        frame_done,
   output logic        busy
);

   localparam logic [11:0] PX_LAST = 12'(H_ACTIVE + H_BLANK - 1);
   localparam logic [11:0] LN_LAST = 12'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);
   localparam logic [11:0] LN_VB0  = 12'(VSYNC_LINES);
   localparam logic [11:0] LN_ACT0 = 12'(VSYNC_LINES + V_BACK);
   localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
   localparam logic [11:0] X_LAST  = 12'(H_ACTIVE - 1);
   localparam logic [11:0] BAR_W   = 12'(H_ACTIVE / 8);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VSYNC  = 2'd1,
      VBACK  = 2'd2,
      ACTIVE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] ln_q, ln_d;
   logic [11:0] px_q, px_d;
   logic [1:0]  mode_q;
   logic [23:0] solid_q;
   logic        latch;
   logic        adv;

   logic        vsync_d, href_d, clken_d, done_d, busy_d;
   logic [23:0] data_d;
   logic        act_pix;
   logic [11:0] x, y;
   logic [2:0]  bar;
   logic [23:0] pattern;

   function automatic state_t line_state(input logic [11:0] l);
      if (l < LN_VB0)       return VSYNC;
      else if (l < LN_ACT0) return VBACK;
      else                  return ACTIVE;
   endfunction

   // Next position / state. Only a non-stalled cycle outside IDLE advances.
   always_comb begin
      state_d = state_q;
      ln_d    = ln_q;
      px_d    = px_q;
      latch   = 1'b0;
      adv     = 1'b0;
      if (state_q == IDLE) begin
         if (en) begin
            state_d = VSYNC;
            ln_d    = '0;
            px_d    = '0;
            latch   = 1'b1;
         end
      end else if (!stall) begin
         adv = 1'b1;
         if (px_q == PX_LAST) begin
            px_d = '0;
            if (ln_q == LN_LAST) begin
               ln_d = '0;
               if (en) begin
                  state_d = VSYNC;
                  latch   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               ln_d    = ln_q + 12'd1;
               state_d = line_state(ln_q + 12'd1);
            end
         end else begin
            px_d = px_q + 12'd1;
         end
      end
   end

   // Outputs are computed from the next position so that they appear on the
   // same edge as the counters. The shadow mode is safe to use directly: a
   // re-latch always lands in VSYNC where no pixel data is emitted.
   always_comb begin
      x   = px_d;
      y   = ln_d - LN_ACT0;
      bar = 3'(x / BAR_W);
      pattern = '0;
      case (mode_q)
         2'd0: begin
            case (bar)
               3'd0:    pattern = 24'hFFFFFF;
               3'd1:    pattern = 24'hFFFF00;
               3'd2:    pattern = 24'h00FFFF;
               3'd3:    pattern = 24'h00FF00;
               3'd4:    pattern = 24'hFF00FF;
               3'd5:    pattern = 24'hFF0000;
               3'd6:    pattern = 24'h0000FF;
               default: pattern = 24'h000000;
            endcase
         end
         2'd1:    pattern = {3{x[7:0]}};
         2'd2:    pattern = {y, x};
         default: pattern = solid_q;
      endcase

      act_pix = (state_d == ACTIVE) && (px_d < H_ACT);
      busy_d  = (state_d != IDLE);

      if ((state_q == IDLE) || !stall) begin
         vsync_d = (state_d == VSYNC);
         href_d  = act_pix;
         clken_d = act_pix;
         data_d  = act_pix ? pattern : '0;
         done_d  = adv && (ln_q == LN_LAST) && (px_q == X_LAST);
      end else begin
         vsync_d = frame_vsync;
         href_d  = frame_href;
         clken_d = 1'b0;
         data_d  = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ln_q        <= '0;
         px_q        <= '0;
         mode_q      <= '0;
         solid_q     <= '0;
         frame_vsync <= 1'b0;
         frame_href  <= 1'b0;
         frame_clken <= 1'b0;
         frame_data  <= '0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         ln_q        <= ln_d;
         px_q        <= px_d;
         if (latch) begin
            mode_q  <= mode;
            solid_q <= solid_rgb;
         end
         frame_vsync <= vsync_d;
         frame_href  <= href_d;
         frame_clken <= clken_d;
         frame_data  <= data_d;
         frame_done  <= done_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_frame_stream_gen.sv
module tb_frame_stream_gen;

   localparam int unsigned HA = 16;
   localparam int unsigned HB = 4;
   localparam int unsigned VA = 4;
   localparam int unsigned VS = 1;
   localparam int unsigned VB = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [23:0] solid_rgb = '0;
   logic        stall = 1'b0;
   logic        frame_vsync, frame_href, frame_clken, frame_done, busy;
   logic [23:0] frame_data;

   logic        en_w = 1'b0;
   logic        stall_w = 1'b0;
   logic [1:0]  mode_w = 2'd1;
   logic [23:0] solid_w = '0;
   logic        vsync_w, href_w, clken_w, done_w, busy_w;
   logic [23:0] data_w;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int pix_cnt = 0;
   int wide_x = 0;
   logic [23:0] exp_q[$];
   int done_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   frame_stream_gen #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS), .V_BACK(VB)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
      .stall(stall), .frame_vsync(frame_vsync), .frame_href(frame_href),
      .frame_clken(frame_clken), .frame_data(frame_data), .frame_done(frame_done),
      .busy(busy)
   );

   frame_stream_gen #(
      .H_ACTIVE(512), .H_BLANK(4), .V_ACTIVE(1), .VSYNC_LINES(1), .V_BACK(0)
   ) u_wide (
      .clk(clk), .reset_n(reset_n), .en(en_w), .mode(mode_w), .solid_rgb(solid_w),
      .stall(stall_w), .frame_vsync(vsync_w), .frame_href(href_w),
      .frame_clken(clken_w), .frame_data(data_w), .frame_done(done_w),
      .busy(busy_w)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected pixel sequence for one frame of the main instance.
   task automatic push_frame(input logic [1:0] m, input logic [23:0] s);
      logic [23:0] bars [8];
      logic [11:0] xx, yy;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      for (int yi = 0; yi < int'(VA); yi++) begin
         for (int xi = 0; xi < int'(HA); xi++) begin
            xx = 12'(xi);
            yy = 12'(yi);
            case (m)
               2'd0:    exp_q.push_back(bars[xi / int'(HA / 8)]);
               2'd1:    exp_q.push_back({3{xx[7:0]}});
               2'd2:    exp_q.push_back({yy, xx});
               default: exp_q.push_back(s);
            endcase
         end
      end
   endtask

   task automatic start_frame(output int s);
      @(negedge clk);
      en = 1'b1;
      tick();
      s = cyc;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   // Scoreboard and event monitor for the main instance.
   initial begin
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (frame_clken) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
               check("pix_unexpected", {8'd0, frame_data}, 32'hFFFFFFFF);
            end else begin
               e = exp_q.pop_front();
               check("pix", {8'd0, frame_data}, {8'd0, e});
            end
         end else if (frame_href) begin
            check("stall_data", {8'd0, frame_data}, 32'd0);
         end
         if (frame_done) done_q.push_back(cyc);
      end
   end

   // Gradient monitor for the 512-wide instance: R=G=B=x[7:0].
   initial begin
      logic [7:0] wx;
      forever begin
         @(negedge clk);
         if (clken_w) begin
            wx = 8'(wide_x);
            check("grad", {8'd0, data_w}, {8'd0, wx, wx, wx});
            wide_x++;
         end
      end
   end

   initial begin
      int s, pc0, n;
      #12;
      check("reset_outs", {26'd0, frame_vsync, frame_href, frame_clken, frame_done, busy,
                           |frame_data}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Mode 0, two back-to-back frames.
      mode = 2'd0;
      push_frame(2'd0, '0);
      push_frame(2'd0, '0);
      done_q.delete();
      pc0 = pix_cnt;
      start_frame(s);
      for (int c = 0; c <= 240; c++) begin
         if (c > 0) tick();
         case (c)
            0:   check("start_vs_busy", {30'd0, frame_vsync, busy}, 32'd3);
            19:  check("vs_19", {31'd0, frame_vsync}, 32'd1);
            20:  check("vs_20", {31'd0, frame_vsync}, 32'd0);
            39:  check("clken_39", {31'd0, frame_clken}, 32'd0);
            40:  check("clken_40", {30'd0, frame_clken, frame_href}, 32'd3);
            119: check("vs_119", {31'd0, frame_vsync}, 32'd0);
            120: check("vs_120", {31'd0, frame_vsync}, 32'd1);
            130: en = 1'b0;
            240: check("busy_240", {31'd0, busy}, 32'd0);
            default: ;
         endcase
      end
      check("m0_done_n", 32'(done_q.size()), 32'd2);
      if (done_q.size() == 2) begin
         check("m0_done0", 32'(done_q[0] - s), 32'd116);
         check("m0_done1", 32'(done_q[1] - s), 32'd236);
      end
      check("m0_pix_n", 32'(pix_cnt - pc0), 32'd128);
      check("m0_q_empty", 32'(exp_q.size()), 32'd0);

      // Mode 2 single frame, en dropped right after start.
      mode = 2'd2;
      push_frame(2'd2, '0);
      start_frame(s);
      en = 1'b0;
      for (int c = 1; c <= 150; c++) begin
         tick();
         if (c == 119) check("m2_busy_119", {31'd0, busy}, 32'd1);
         if (c >= 120) check("m2_busy_low", {31'd0, busy}, 32'd0);
      end
      check("m2_q_empty", 32'(exp_q.size()), 32'd0);

      // Stall for 3 cycles after pixel x=4,y=1 so x=5 is pending.
      push_frame(2'd2, '0);
      done_q.delete();
      start_frame(s);
      en = 1'b0;
      n = 0;
      while (!(frame_clken && frame_data == 24'h001004) && n < 200) begin
         tick();
         n++;
      end
      check("stall_reach", 32'(n < 200), 32'd1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_clken_href", {30'd0, frame_clken, frame_href}, 32'd1);
      end
      stall = 1'b0;
      tick();
      check("stall_resume", {7'd0, frame_clken, frame_data}, {7'd0, 1'b1, 24'h001005});
      wait_idle(200);
      check("stall_done_n", 32'(done_q.size()), 32'd1);
      if (done_q.size() == 1) check("stall_done_at", 32'(done_q[0] - s), 32'd119);
      check("stall_q_empty", 32'(exp_q.size()), 32'd0);

      // Mode change mid-frame: bars then solid; later solid_rgb changes ignored.
      mode = 2'd0;
      push_frame(2'd0, '0);
      push_frame(2'd3, 24'h123456);
      start_frame(s);
      for (int c = 1; c <= 245; c++) begin
         tick();
         if (c == 60) begin
            mode = 2'd3;
            solid_rgb = 24'h123456;
         end
         if (c == 130) en = 1'b0;
         if (c == 150) begin
            solid_rgb = 24'hABCDEF;
            mode = 2'd1;
         end
      end
      check("mc_busy", {31'd0, busy}, 32'd0);
      check("mc_q_empty", 32'(exp_q.size()), 32'd0);

      // Reset asserted mid-frame at x=7,y=2.
      mode = 2'd2;
      push_frame(2'd2, '0);
      done_q.delete();
      start_frame(s);
      n = 0;
      while (!(frame_clken && frame_data == 24'h002007) && n < 200) begin
         tick();
         n++;
      end
      check("rst_reach", 32'(n < 200), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_outs", {26'd0, frame_vsync, frame_href, frame_clken, frame_done, busy,
                               |frame_data}, 32'd0);
      exp_q.delete();
      tick();
      tick();
      tick();
      check("rst_no_done", 32'(done_q.size()), 32'd0);
      push_frame(2'd2, '0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      s = cyc;
      check("rst_restart", {30'd0, frame_vsync, busy}, 32'd3);
      en = 1'b0;
      wait_idle(200);
      check("rst_done_n", 32'(done_q.size()), 32'd1);
      if (done_q.size() == 1) check("rst_done_at", 32'(done_q[0] - s), 32'd116);
      check("rst_q_empty", 32'(exp_q.size()), 32'd0);

      // 512-wide gradient: wraps to 00 at x=256.
      @(negedge clk);
      en_w = 1'b1;
      tick();
      en_w = 1'b0;
      n = 0;
      while (busy_w && n < 3000) begin
         tick();
         n++;
      end
      check("wide_idle", {31'd0, busy_w}, 32'd0);
      check("wide_pix_n", 32'(wide_x), 32'd512);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
